snake_sprite_bank: RTL
======================

SNAKE_SPRITE_BANK -- requirements
Module: snake_sprite_bank

Interface
REQ-001 SHALL have parameter NUM_SPRITES, default 8, number of sprite slots (power of two, >= 2).
REQ-002 SHALL have parameter SPRITE_DIM, default 16, sprite edge in pixels (power of two).
REQ-003 SHALL have parameter PIXEL_W, default 16, pixel width in bits (multiple of 8).
REQ-004 SHALL have parameter TRANSPARENT_KEY, default 0, pixel value reported as transparent.
REQ-005 SHALL have parameter INIT_FILE, default "", memory init image.
REQ-006 SHALL have ports: clk  in  1  sole clock, all logic on rising edge; reset  in  1  synchronous, active-high.
REQ-007 SHALL have host ports: address  in  AW=log2(NUM_SPRITES*SPRITE_DIM^2)  word address; chipselect, read, write  in  1; byteenable  in  PIXEL_W/8; writedata  in  PIXEL_W; readdata  out  PIXEL_W; readdatavalid  out  1; waitrequest  out  1.
REQ-008 SHALL have fill ports: fill_start  in  1; fill_sprite  in  log2(NUM_SPRITES); fill_color  in  PIXEL_W; fill_busy  out  1; fill_done  out  1 (pulse).
REQ-009 SHALL have display ports: req_valid  in  1; req_sprite  in  log2(NUM_SPRITES); req_x, req_y  in  log2(SPRITE_DIM); req_orient  in  2; pix_valid  out  1; pix_data  out  PIXEL_W; pix_opaque  out  1.

Function
REQ-010 SHALL store NUM_SPRITES*SPRITE_DIM^2 words, row-major per slot: word = sprite*DIM^2 + y*DIM + x.
REQ-011 SHALL use a dual-port memory: port A host/fill read-write, port B display read-only; port B read of a word written same cycle returns old data.
REQ-012 Host write accepted when chipselect&write&!waitrequest; only bytes with byteenable=1 update.
REQ-013 Host read accepted when chipselect&read&!waitrequest; readdata valid with readdatavalid=1 exactly one cycle later; readdatavalid=0 otherwise.
REQ-014 Fill FSM states IDLE, FILL; IDLE->FILL when fill_start=1 in IDLE (fill_sprite, fill_color latched); fill_start in FILL ignored.
REQ-015 FILL SHALL write fill_color to slot words 0..DIM^2-1, one per cycle, full byteenable; start sampled cycle T -> writes T+1..T+DIM^2.
REQ-016 At T+DIM^2+1: state IDLE, fill_busy=0, fill_done=1 for exactly one cycle.
REQ-017 fill_busy=1 and waitrequest=1 iff state FILL; host request in same cycle as fill_start is accepted normally.
REQ-018 Display path fully pipelined, one request per cycle, latency 2: req_valid at T -> pix_valid at T+2 with that request's pixel.
REQ-019 Source coordinates by req_orient (M=DIM-1): 0: (x,y); 1 (90 cw): (y, M-x); 2 (180): (M-x, M-y); 3 (270 cw): (M-y, x).
REQ-020 pix_opaque = (pix_data != TRANSPARENT_KEY) when pix_valid; 0 otherwise.
REQ-021 Display path SHALL never stall; fill and host traffic do not affect its latency.

Reset
REQ-022 Reset SHALL set: FSM IDLE, fill_busy=0, fill_done=0, waitrequest=0, readdatavalid=0, readdata=0, pix_valid=0, pix_data=0, pix_opaque=0.
REQ-023 Reset SHALL NOT alter memory contents; reset mid-fill aborts, already-written words keep fill_color, no fill_done.
REQ-024 Requests in flight at reset SHALL be discarded (no readdatavalid/pix_valid after reset).

Structure
REQ-025 Shared package SHALL hold orientation encodings (ORIENT_0/90/180/270) and FSM state enum.
REQ-026 Dual-port memory SHALL be one sub-module, sprite_bank_dpram (byte-enabled port A, read-only port B, registered outputs, INIT_FILE).
REQ-027 Address transform and fill FSM SHALL live in the top module.

Verification (defaults)
REQ-028 Host write 0x1234 addr 0x105 be=11, read 0x105 -> readdatavalid next cycle, readdata 0x1234; write 0xAB00 be=10 -> read 0xAB34.
REQ-029 fill_start slot 3, color 0x07E0 at T -> busy T+1..T+256, done only T+257; words 0x300..0x3FF=0x07E0; 0x2FF, 0x400 unchanged.
REQ-030 Slot 1 word (x=2,y=0)=0xF800: req (x=2,y=0,o=0), (x=15,y=2,o=1), (x=13,y=15,o=2), (x=0,y=13,o=3) back-to-back -> four pix_valid cycles, each 0xF800, opaque=1.
REQ-031 Host write/read during fill -> waitrequest=1 held, accepted at T+257; display reads of slot 3 continue at latency 2.
REQ-032 Reset at T+100 of fill -> busy=0 next cycle, no fill_done, words 0x300..0x362 = fill_color, 0x363 unchanged.
REQ-033 Pixel equal TRANSPARENT_KEY read on display -> pix_valid=1, pix_opaque=0.

Source files
------------

// File: rtl/snake_sprite_bank_pkg.sv
// Shared types for the sprite bank: display orientation codes and fill FSM states.
package snake_sprite_bank_pkg;

  typedef enum logic [1:0] {
    ORIENT_0   = 2'd0,
    ORIENT_90  = 2'd1,
    ORIENT_180 = 2'd2,
    ORIENT_270 = 2'd3
  } orient_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_FILL = 1'b1
  } fill_state_e;

endpackage

// File: rtl/snake_sprite_bank_if.sv
// Host word bus and display request/pixel bus of the sprite bank.
interface snake_sprite_bank_if #(
  parameter int NUM_SPRITES = 8,
  parameter int SPRITE_DIM  = 16,
  parameter int PIXEL_W     = 16
) ();
  localparam int SW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(SPRITE_DIM);
  localparam int AW = SW + 2 * CW;
  localparam int BW = PIXEL_W / 8;

  // Host: a transfer happens in any cycle with chipselect & (read|write) & !waitrequest;
  // read data returns with readdatavalid exactly one cycle later. Display: every cycle
  // with req_valid is a request (no back-pressure); pix_valid answers it two cycles later.
  logic [AW-1:0]      address;
  logic               chipselect;
  logic               read;
  logic               write;
  logic [BW-1:0]      byteenable;
  logic [PIXEL_W-1:0] writedata;
  logic [PIXEL_W-1:0] readdata;
  logic               readdatavalid;
  logic               waitrequest;

  logic               req_valid;
  logic [SW-1:0]      req_sprite;
  logic [CW-1:0]      req_x;
  logic [CW-1:0]      req_y;
  logic [1:0]         req_orient;
  logic               pix_valid;
  logic [PIXEL_W-1:0] pix_data;
  logic               pix_opaque;

  modport master (
    output address, chipselect, read, write, byteenable, writedata,
    output req_valid, req_sprite, req_x, req_y, req_orient,
    input  readdata, readdatavalid, waitrequest,
    input  pix_valid, pix_data, pix_opaque
  );

  modport slave (
    input  address, chipselect, read, write, byteenable, writedata,
    input  req_valid, req_sprite, req_x, req_y, req_orient,
    output readdata, readdatavalid, waitrequest,
    output pix_valid, pix_data, pix_opaque
  );
endinterface

// File: rtl/snake_sprite_bank_dpram.sv
// Sprite pixel store: byte-enabled read/write port A, read-only port B, registered reads.
module sprite_bank_dpram #(
  parameter int DEPTH     = 2048,
  parameter int AW        = 11,
  parameter int DW        = 16,
  parameter     INIT_FILE = ""
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   a_addr,
  input  logic            a_we,
  input  logic [DW/8-1:0] a_be,
  input  logic [DW-1:0]   a_wdata,
  input  logic            a_re,
  output logic [DW-1:0]   a_rdata,
  input  logic [AW-1:0]   b_addr,
  output logic [DW-1:0]   b_rdata
);
  localparam int BW = DW / 8;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] a_rdata_q;
  logic [DW-1:0] b_rdata_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < BW; i++) begin
      if (a_we && a_be[i]) mem[a_addr][8*i +: 8] <= a_wdata[8*i +: 8];
    end
  end

  // Only the output register clears on reset; stored pixels survive it.
  always_ff @(posedge clk) begin
    if (rst)       a_rdata_q <= '0;
    else if (a_re) a_rdata_q <= mem[a_addr];
  end

  // Separate process: a same-cycle port A write is not yet visible here.
  always_ff @(posedge clk) begin
    b_rdata_q <= mem[b_addr];
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;
endmodule

// File: rtl/snake_sprite_bank.sv
// Sprite bank top: host access, slot fill engine and a never-stalling rotated display read path.
module snake_sprite_bank
  import snake_sprite_bank_pkg::*;
#(
  parameter int                 NUM_SPRITES     = 8,
  parameter int                 SPRITE_DIM      = 16,
  parameter int                 PIXEL_W         = 16,
  parameter logic [PIXEL_W-1:0] TRANSPARENT_KEY = '0,
  parameter                     INIT_FILE       = ""
) (
  input  logic                           clk,
  input  logic                           reset,
  snake_sprite_bank_if.slave             bus,
  input  logic                           fill_start,
  input  logic [$clog2(NUM_SPRITES)-1:0] fill_sprite,
  input  logic [PIXEL_W-1:0]             fill_color,
  output logic                           fill_busy,
  output logic                           fill_done,
  output fill_state_e                    dbg_state
);
  localparam int SW    = $clog2(NUM_SPRITES);
  localparam int CW    = $clog2(SPRITE_DIM);
  localparam int PW    = 2 * CW;
  localparam int AW    = SW + PW;
  localparam int BW    = PIXEL_W / 8;
  localparam int DEPTH = NUM_SPRITES * SPRITE_DIM * SPRITE_DIM;
  localparam logic [CW-1:0] M = CW'(SPRITE_DIM - 1);

  fill_state_e        state_q;
  logic [SW-1:0]      fill_sprite_q;
  logic [PIXEL_W-1:0] fill_color_q;
  logic [PW-1:0]      fill_cnt_q;
  logic               fill_busy_q, fill_done_q, waitrequest_q;

  // Fill FSM: one slot word per cycle, done pulses the cycle after the last write.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      fill_cnt_q    <= '0;
      fill_busy_q   <= 1'b0;
      fill_done_q   <= 1'b0;
      waitrequest_q <= 1'b0;
    end else begin
      fill_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fill_start) begin
            state_q       <= ST_FILL;
            fill_sprite_q <= fill_sprite;
            fill_color_q  <= fill_color;
            fill_cnt_q    <= '0;
            fill_busy_q   <= 1'b1;
            waitrequest_q <= 1'b1;
          end
        end
        ST_FILL: begin
          fill_cnt_q <= fill_cnt_q + 1'b1;
          if (fill_cnt_q == '1) begin
            state_q       <= ST_IDLE;
            fill_busy_q   <= 1'b0;
            waitrequest_q <= 1'b0;
            fill_done_q   <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  logic [AW-1:0]      a_addr;
  logic               a_we, a_re;
  logic [BW-1:0]      a_be;
  logic [PIXEL_W-1:0] a_wdata;
  logic [PIXEL_W-1:0] a_rdata;

  always_comb begin
    a_addr  = bus.address;
    a_wdata = bus.writedata;
    a_be    = bus.byteenable;
    a_we    = 1'b0;
    a_re    = 1'b0;
    if (state_q == ST_FILL) begin
      a_addr  = {fill_sprite_q, fill_cnt_q};
      a_wdata = fill_color_q;
      a_be    = '1;
      a_we    = 1'b1;
    end else if (bus.chipselect && !waitrequest_q) begin
      a_we = bus.write;
      a_re = bus.read;
    end
    // A reset cycle neither writes nor launches a read.
    if (reset) begin
      a_we = 1'b0;
      a_re = 1'b0;
    end
  end

  logic [CW-1:0] src_x, src_y;
  logic [AW-1:0] b_addr;

  always_comb begin
    src_x = bus.req_x;
    src_y = bus.req_y;
    case (orient_e'(bus.req_orient))
      ORIENT_90:  begin src_x = bus.req_y;     src_y = M - bus.req_x; end
      ORIENT_180: begin src_x = M - bus.req_x; src_y = M - bus.req_y; end
      ORIENT_270: begin src_x = M - bus.req_y; src_y = bus.req_x;     end
      default:    begin src_x = bus.req_x;     src_y = bus.req_y;     end
    endcase
    b_addr = {bus.req_sprite, src_y, src_x};
  end

  logic [PIXEL_W-1:0] b_rdata;

  sprite_bank_dpram #(
    .DEPTH     (DEPTH),
    .AW        (AW),
    .DW        (PIXEL_W),
    .INIT_FILE (INIT_FILE)
  ) u_dpram (
    .clk     (clk),
    .rst     (reset),
    .a_addr  (a_addr),
    .a_we    (a_we),
    .a_be    (a_be),
    .a_wdata (a_wdata),
    .a_re    (a_re),
    .a_rdata (a_rdata),
    .b_addr  (b_addr),
    .b_rdata (b_rdata)
  );

  logic               rdv_d, rdv_q;
  logic               s1_valid_d, s1_valid_q;
  logic               pix_valid_d, pix_valid_q;
  logic [PIXEL_W-1:0] pix_data_d, pix_data_q;
  logic               pix_opaque_d, pix_opaque_q;

  always_comb begin
    rdv_d        = a_re;
    s1_valid_d   = bus.req_valid;
    pix_valid_d  = s1_valid_q;
    pix_data_d   = s1_valid_q ? b_rdata : '0;
    pix_opaque_d = s1_valid_q && (b_rdata != TRANSPARENT_KEY);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rdv_q        <= 1'b0;
      s1_valid_q   <= 1'b0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      pix_opaque_q <= 1'b0;
    end else begin
      rdv_q        <= rdv_d;
      s1_valid_q   <= s1_valid_d;
      pix_valid_q  <= pix_valid_d;
      pix_data_q   <= pix_data_d;
      pix_opaque_q <= pix_opaque_d;
    end
  end

  assign bus.readdata      = a_rdata;
  assign bus.readdatavalid = rdv_q;
  assign bus.waitrequest   = waitrequest_q;
  assign bus.pix_valid     = pix_valid_q;
  assign bus.pix_data      = pix_data_q;
  assign bus.pix_opaque    = pix_opaque_q;
  assign fill_busy         = fill_busy_q;
  assign fill_done         = fill_done_q;
  assign dbg_state         = state_q;
endmodule
